// File: rtl/aes_core_sched.sv
// ---------------------------------------------------------------------------
// aes_core_sched
//
// Purpose:
//   Front-end scheduler for a single AES cipher core that is shared by two
//   requesters. One job runs at a time. The scheduler:
//     - picks one pending requester with a round-robin arbiter,
//     - registers that requester's key and plaintext,
//     - strobes the core's load input,
//     - waits for the core's done pulse, but gives up after a bounded number
//       of cycles,
//     - holds the result for the owning requester until it is consumed.
//   A job that times out returns all-zero data with the error flag set.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous, active-high reset
//   req_valid_i[1:0] requester i has a job pending
//   req_ready_o[1:0] job of requester i is accepted this cycle
//   req_key0_i/1_i   128-bit key for requester 0 / 1
//   req_text0_i/1_i  128-bit plaintext for requester 0 / 1
//   resp_valid_o[1:0] result available for requester i
//   resp_ready_i[1:0] requester i consumes its result
//   resp_data_o      128-bit ciphertext, zero when the job was aborted
//   resp_err_o       1 when the job was aborted by the timeout
//   core_ld_o        one-cycle load strobe to the cipher core
//   core_key_o       registered key driven to the core
//   core_text_o      registered plaintext driven to the core
//   core_done_i      completion pulse from the core
//   core_text_out_i  core ciphertext, valid while core_done_i is high
//
// Parameters:
//   TIMEOUT_CYCLES   number of BUSY cycles to wait for core_done_i
//   CNT_W            timeout counter width, 2**CNT_W must exceed
//                    TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module aes_core_sched #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [127:0] req_key0_i,
  input  logic [127:0] req_key1_i,
  input  logic [127:0] req_text0_i,
  input  logic [127:0] req_text1_i,
  output logic [1:0]   resp_valid_o,
  input  logic [1:0]   resp_ready_i,
  output logic [127:0] resp_data_o,
  output logic         resp_err_o,
  output logic         core_ld_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_text_o,
  input  logic         core_done_i,
  input  logic [127:0] core_text_out_i
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Requester that won the previous arbitration; the other one wins a tie.
  logic last_grant;
  // Requester that owns the job currently in flight.
  logic job_idx;
  logic [CNT_W-1:0] timeout_cnt;
  logic [CNT_W-1:0] timeout_cnt_inc;
  logic [127:0] result;
  logic err;

  logic grant_any;
  logic grant_sel;
  logic accept;
  logic timeout_hit;
  logic resp_done;

  // Round-robin choice between the two requesters. With a single requester
  // pending it simply wins; with both pending the one that was not served
  // last time wins, so neither can starve the other.
  always_comb begin
    grant_any = |req_valid_i;
    if (req_valid_i == 2'b11) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req_valid_i[1];
    end
  end

  // Event decodes shared by the next-state logic, the outputs and the
  // datapath. Acceptance is suppressed while reset is asserted so that no
  // requester sees a handshake that the reset will throw away.
  // The timeout fires in the BUSY cycle whose increment would reach
  // TIMEOUT_CYCLES; a done pulse in that same cycle still wins.
  always_comb begin
    accept          = (state == IDLE) && !rst && grant_any;
    timeout_cnt_inc = timeout_cnt + 1'b1;
    timeout_hit     = (state == BUSY) && !core_done_i &&
                      (timeout_cnt_inc == TIMEOUT_VAL);
    resp_done       = (state == RESP) && resp_ready_i[job_idx];
  end

  // State register. Reset returns to IDLE from anywhere, which abandons any
  // job in flight without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. core_done_i only matters in BUSY; a late or spurious
  // pulse in any other state has no effect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = BUSY;
      end
      BUSY: begin
        if (core_done_i || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. The ready handshake is combinational so that a pending
  // requester is taken in the same IDLE cycle, which keeps consecutive jobs
  // separated by a single IDLE cycle. The response valid points only at the
  // requester that owns the current job.
  always_comb begin
    req_ready_o  = 2'b00;
    resp_valid_o = 2'b00;
    core_ld_o    = 1'b0;
    if (accept) begin
      req_ready_o[grant_sel] = 1'b1;
    end
    if (state == RESP) begin
      resp_valid_o[job_idx] = 1'b1;
    end
    if (state == LOAD) begin
      core_ld_o = 1'b1;
    end
  end

  // Job datapath: captures the winning request, runs the timeout counter and
  // records the outcome. The result and error registers are only written in
  // BUSY, so they stay stable for as long as the response is back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      job_idx     <= 1'b0;
      timeout_cnt <= '0;
      result      <= '0;
      err         <= 1'b0;
      core_key_o  <= '0;
      core_text_o <= '0;
    end else begin
      if (accept) begin
        job_idx     <= grant_sel;
        last_grant  <= grant_sel;
        core_key_o  <= grant_sel ? req_key1_i  : req_key0_i;
        core_text_o <= grant_sel ? req_text1_i : req_text0_i;
      end
      case (state)
        LOAD: begin
          timeout_cnt <= '0;
        end
        BUSY: begin
          if (core_done_i) begin
            result <= core_text_out_i;
            err    <= 1'b0;
          end else begin
            timeout_cnt <= timeout_cnt_inc;
            if (timeout_hit) begin
              result <= '0;
              err    <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    resp_data_o = result;
    resp_err_o  = err;
  end

endmodule
